control_ls: RTL
===============

CONTROL_LS -- requirements
Module: control_ls

Interface
REQ-001 Parameter MEM_WAIT, default 1, number of cycles the FSM holds mem_cmd=READ before data is sampled; legal range 1..15.
REQ-002 Parameter STATE_W, default 5, width of the state register; all state codes SHALL fit in it.
REQ-003 clk  in  1  single clock; all state and counter updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces state RST and clears the wait counter immediately.
REQ-005 opcode  in  3  instruction opcode from the instruction register; op  in  2  instruction op field.
REQ-006 load_ir, load_addr, load_pc, reset_pc, addr_sel  out  1 each  IR enable, data-address register enable, PC enable, PC mux reset select, address mux select (1=PC, 0=data address).
REQ-007 mem_cmd  out  2  00=none, 01=READ, 10=WRITE.
REQ-008 vsel  out  2  register-file write-data select: 00=C, 10=sximm8, 11=mdata.
REQ-009 write, loada, loadb, asel, bsel, loadc, loads  out  1 each  register-file write, A/B/C/status enables, A-zero select, B-sximm5 select.
REQ-010 nsel  out  3  one-hot register select: 100=Rn, 010=Rd, 001=Rm.
REQ-011 halted  out  1  high in HALT; illegal  out  1  high in HALT when entered from an undefined encoding.

Function
REQ-012 Outputs SHALL be a pure decode of the present state (Moore); every output SHALL have a defined value in every state, and any output not listed for a state SHALL be 0.
REQ-013 States: RST, IF1, IF2, UPC, DEC, MOVI, GETB, GETA, ALU, CMP, MOVR, WB, LDA, ADR, LADR, LRD, LWB, SGB, SMC, SWR, HALT.
REQ-014 RST: reset_pc=1, load_pc=1; next IF1.
REQ-015 IF1: addr_sel=1, mem_cmd=READ; held exactly MEM_WAIT cycles by a down-counter loaded on entry; then IF2.
REQ-016 IF2: addr_sel=1, mem_cmd=READ, load_ir=1; next UPC. UPC: load_pc=1; next DEC.
REQ-017 DEC decode on {opcode,op}: 110_10 -> MOVI; 110_00 -> GETB; 101_xx -> GETB; 011_00 -> LDA; 100_00 -> LDA; 111_xx -> HALT (illegal=0); any other -> HALT (illegal=1).
REQ-018 MOVI: vsel=10, write=1, nsel=100; next IF1.
REQ-019 GETB: loadb=1, nsel=001; next MOVR for 110_00 or 101_11, else GETA.
REQ-020 GETA: loada=1, nsel=100; next CMP for 101_01, else ALU.
REQ-021 ALU: loadc=1; next WB. MOVR: asel=1, loadc=1; next WB. CMP: loads=1; next IF1.
REQ-022 WB: vsel=00, write=1, nsel=010; next IF1.
REQ-023 LDA: loada=1, nsel=100; next ADR. ADR: bsel=1, loadc=1; next LADR. LADR: load_addr=1; next LRD for 011_00, SGB for 100_00.
REQ-024 LRD: addr_sel=0, mem_cmd=READ; held MEM_WAIT cycles via the same counter; then LWB. LWB: addr_sel=0, mem_cmd=READ, vsel=11, write=1, nsel=010; next IF1.
REQ-025 SGB: loadb=1, nsel=010; next SMC. SMC: asel=1, loadc=1; next SWR. SWR: addr_sel=0, mem_cmd=WRITE for exactly one cycle; next IF1.
REQ-026 HALT: halted=1, all enables 0, mem_cmd=00; remains until reset; opcode/op changes SHALL NOT leave HALT.
REQ-027 Wait counter SHALL be 4 bits, idle at 0 outside IF1/LRD; it SHALL NOT wrap, and MEM_WAIT=1 SHALL give single-cycle IF1/LRD.
REQ-028 Unreachable state codes SHALL transition to RST on the next clock.

Reset
REQ-029 Reset asserted in any state, including mid-wait in IF1/LRD or during SWR, SHALL within the same cycle force RST outputs (reset_pc=1, load_pc=1, mem_cmd=00, write=0).
REQ-030 After reset deassertion, the first rising edge SHALL move RST -> IF1.

Verification
REQ-031 MEM_WAIT=1, MOV R0,#5 (110_10): state sequence RST,IF1,IF2,UPC,DEC,MOVI,IF1; MOVI has vsel=10, write=1, nsel=100.
REQ-032 MEM_WAIT=3, ADD (101_00): IF1 asserts mem_cmd=01 for exactly 3 cycles; then GETB,GETA,ALU,WB with nsel 001,100,--,010.
REQ-033 MEM_WAIT=2, LDR (011_00): LDA,ADR,LADR, LRD 2 cycles mem_cmd=01 addr_sel=0, LWB vsel=11 write=1 nsel=010, then IF1.
REQ-034 STR (100_00): SGB nsel=010, SMC asel=1, SWR mem_cmd=10 for one cycle only, then IF1.
REQ-035 Decode 111_00 -> halted=1, illegal=0, held 20 cycles with random opcode; decode 000_00 -> halted=1, illegal=1; reset exits both to RST.
REQ-036 Reset pulse asserted asynchronously mid-LRD wait (MEM_WAIT=4): outputs match RST before next edge; counter reads 0; fetch restarts cleanly.

Source files
------------

// File: rtl/control_ls.sv
// control_ls: Moore control FSM for a load/store datapath.
// Sequences instruction fetch, decode, ALU, load and store micro-steps,
// stretching memory reads by MEM_WAIT cycles with a 4-bit down-counter.
module control_ls #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned STATE_W  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       load_ir,
  output logic       load_addr,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic [2:0] nsel,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_MOVI, S_GETB, S_GETA, S_ALU, S_CMP,
    S_MOVR, S_WB, S_LDA, S_ADR, S_LADR, S_LRD, S_LWB, S_SGB, S_SMC, S_SWR,
    S_HALT
  } state_t;

  localparam logic [1:0] MC_NONE  = 2'b00;
  localparam logic [1:0] MC_READ  = 2'b01;
  localparam logic [1:0] MC_WRITE = 2'b10;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       wait_load;
  logic       ill_q;
  state_t     dec_next;
  logic       dec_ill;
  logic [4:0] instr;

  assign instr = {opcode, op};

  // Counter is reloaded only on entry into a wait state, so it sits at 0 elsewhere
  assign wait_load = ((state_next == S_IF1) && (state != S_IF1)) ||
                     ((state_next == S_LRD) && (state != S_LRD));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  // Memory wait down-counter; saturates at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wait_cnt <= '0;
    else if (wait_load)     wait_cnt <= WAIT_LOAD;
    else if (wait_cnt != 0) wait_cnt <= wait_cnt - 4'd1;
  end

  // Remembers whether HALT was reached through an undefined encoding
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               ill_q <= 1'b0;
    else if (state == S_DEC) ill_q <= dec_ill;
  end

  // Instruction decode for the DEC state
  always_comb begin
    dec_next = S_HALT;
    dec_ill  = 1'b1;
    casez (instr)
      5'b110_10: begin dec_next = S_MOVI; dec_ill = 1'b0; end
      5'b110_00: begin dec_next = S_GETB; dec_ill = 1'b0; end
      5'b101_??: begin dec_next = S_GETB; dec_ill = 1'b0; end
      5'b011_00: begin dec_next = S_LDA;  dec_ill = 1'b0; end
      5'b100_00: begin dec_next = S_LDA;  dec_ill = 1'b0; end
      5'b111_??: begin dec_next = S_HALT; dec_ill = 1'b0; end
      default:   begin dec_next = S_HALT; dec_ill = 1'b1; end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = S_RST;
    case (state)
      S_RST:  state_next = S_IF1;
      S_IF1:  state_next = (wait_cnt == 0) ? S_IF2 : S_IF1;
      S_IF2:  state_next = S_UPC;
      S_UPC:  state_next = S_DEC;
      S_DEC:  state_next = dec_next;
      S_MOVI: state_next = S_IF1;
      S_GETB: state_next = (instr == 5'b110_00 || instr == 5'b101_11) ? S_MOVR : S_GETA;
      S_GETA: state_next = (instr == 5'b101_01) ? S_CMP : S_ALU;
      S_ALU:  state_next = S_WB;
      S_MOVR: state_next = S_WB;
      S_CMP:  state_next = S_IF1;
      S_WB:   state_next = S_IF1;
      S_LDA:  state_next = S_ADR;
      S_ADR:  state_next = S_LADR;
      S_LADR: state_next = (instr == 5'b011_00) ? S_LRD : S_SGB;
      S_LRD:  state_next = (wait_cnt == 0) ? S_LWB : S_LRD;
      S_LWB:  state_next = S_IF1;
      S_SGB:  state_next = S_SMC;
      S_SMC:  state_next = S_SWR;
      S_SWR:  state_next = S_IF1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  // Moore output decode
  always_comb begin
    load_ir   = 1'b0;
    load_addr = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MC_NONE;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    nsel      = 3'b000;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_RST:  begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:  begin addr_sel = 1'b1; mem_cmd = MC_READ; end
      S_IF2:  begin addr_sel = 1'b1; mem_cmd = MC_READ; load_ir = 1'b1; end
      S_UPC:  load_pc = 1'b1;
      S_MOVI: begin vsel = 2'b10; write = 1'b1; nsel = 3'b100; end
      S_GETB: begin loadb = 1'b1; nsel = 3'b001; end
      S_GETA: begin loada = 1'b1; nsel = 3'b100; end
      S_ALU:  loadc = 1'b1;
      S_MOVR: begin asel = 1'b1; loadc = 1'b1; end
      S_CMP:  loads = 1'b1;
      S_WB:   begin vsel = 2'b00; write = 1'b1; nsel = 3'b010; end
      S_LDA:  begin loada = 1'b1; nsel = 3'b100; end
      S_ADR:  begin bsel = 1'b1; loadc = 1'b1; end
      S_LADR: load_addr = 1'b1;
      S_LRD:  mem_cmd = MC_READ;
      S_LWB:  begin mem_cmd = MC_READ; vsel = 2'b11; write = 1'b1; nsel = 3'b010; end
      S_SGB:  begin loadb = 1'b1; nsel = 3'b010; end
      S_SMC:  begin asel = 1'b1; loadc = 1'b1; end
      S_SWR:  mem_cmd = MC_WRITE;
      S_HALT: begin halted = 1'b1; illegal = ill_q; end
      default: ;
    endcase
  end

endmodule
